// File: rtl/axi_burst_addr_gen_pkg.sv
// axi_burst_addr_gen_pkg: shared AXI burst types, widths, 4KB page constant and command legality check.
package axi_burst_addr_gen_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_4KB_PAGE   = 4096;

    typedef logic [AXI_ADDR_WIDTH-1:0] axi_address;
    typedef logic [AXI_ID_WIDTH-1:0]   axi_id;

    typedef enum logic [2:0] {
        SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B
    } axi_burst_size;

    typedef enum logic [1:0] {
        BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD
    } axi_burst_type;

    typedef enum logic {IDLE, BURST} gen_state_e;

    // Only the page offset of the address matters: the 4KB test looks at
    // bits [11:0] and the wrap alignment test at most at bits [6:0].
    function automatic logic cmd_illegal(input logic [11:0] addr, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst,
                                         input int unsigned max_size);
        logic [11:0] nb_m1;
        logic [16:0] end_off;
        nb_m1   = ~(12'hFFF << size);
        end_off = 17'(addr & ~nb_m1) + ((17'(len) + 17'd1) << size);
        return (32'(size) > max_size) || (burst == BURST_RSVD) ||
               (burst == BURST_WRAP && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (addr & nb_m1) != 12'd0)) ||
               (burst == BURST_INCR && end_off > 17'(AXI_4KB_PAGE));
    endfunction

endpackage

// File: rtl/axi_beat_strb_calc.sv
// axi_beat_strb_calc: byte-lane strobe for one beat from its address and transfer size.
// Ports: addr_i  - beat address bits that select a lane within the bus word
//        size_i  - AXI size (2^size bytes per beat)
//        strb_o  - lanes from the address offset up to the end of the size-aligned slot
module axi_beat_strb_calc #(
    parameter int DATA_WIDTH = 64,
    localparam int BW = DATA_WIDTH / 8,
    localparam int OFF_W = (BW > 1) ? $clog2(BW) : 1
) (
    input  logic [OFF_W-1:0] addr_i,
    input  logic [2:0]       size_i,
    output logic [BW-1:0]    strb_o
);

    int unsigned nb, lo, hi;

    always_comb begin
        nb = 32'd1 << size_i;
        lo = 32'(addr_i) % BW;
        hi = ((32'(addr_i) & ~(nb - 32'd1)) % BW) + nb - 32'd1;
        strb_o = '0;
        for (int i = 0; i < BW; i++) begin
            strb_o[i] = (32'(i) >= lo) && (32'(i) <= hi);
        end
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: turns one AXI AW/AR command into a stream of beat descriptors.
// Ports: clk_i/rst_i                  - clock, synchronous active-high reset
//        cmd_*                        - command handshake and fields (addr, len, size, burst, id)
//        beat_valid_o/beat_ready_i    - beat handshake
//        beat_addr/strb/idx/last/id_o - current beat descriptor
//        err_o                        - one-cycle pulse when an illegal command is dropped
module axi_burst_addr_gen
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [7:0]              cmd_len_i,
    input  logic [2:0]              cmd_size_i,
    input  logic [1:0]              cmd_burst_i,
    input  logic [ID_WIDTH-1:0]     cmd_id_i,
    output logic                    beat_valid_o,
    input  logic                    beat_ready_i,
    output logic [ADDR_WIDTH-1:0]   beat_addr_o,
    output logic [DATA_WIDTH/8-1:0] beat_strb_o,
    output logic [7:0]              beat_idx_o,
    output logic                    beat_last_o,
    output logic [ID_WIDTH-1:0]     beat_id_o,
    output logic                    err_o
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int OFF_W = (BW > 1) ? $clog2(BW) : 1;
    localparam int unsigned MAX_SIZE = $clog2(BW);
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    gen_state_e              state_q, state_d;
    axi_burst_type           burst_q, burst_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, wrap_mask_q, wrap_mask_d, nb, next_addr;
    logic [2:0]              size_q, size_d;
    logic [7:0]              len_q, len_d, idx_q, idx_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    err_q, err_d, cmd_hs, illegal;
    logic [BW-1:0]           strb;

    axi_beat_strb_calc #(.DATA_WIDTH(DATA_WIDTH)) u_strb (
        .addr_i (addr_q[OFF_W-1:0]),
        .size_i (size_q),
        .strb_o (strb)
    );

    assign cmd_ready_o  = (state_q == IDLE) && !rst_i;
    assign beat_valid_o = state_q == BURST;
    assign beat_last_o  = beat_valid_o && (idx_q == len_q);
    assign beat_strb_o  = beat_valid_o ? strb : '0;
    assign beat_addr_o  = addr_q;
    assign beat_idx_o   = idx_q;
    assign beat_id_o    = id_q;
    assign err_o        = err_q;

    always_comb begin
        cmd_hs  = cmd_valid_i && cmd_ready_o;
        illegal = cmd_illegal(cmd_addr_i[11:0], cmd_len_i, cmd_size_i, cmd_burst_i, MAX_SIZE);
        nb      = ONE << size_q;
        // Wrap keeps the bits above the wrap window and lets the low bits roll over.
        next_addr = burst_q == BURST_FIXED ? addr_q :
                    burst_q == BURST_WRAP  ? (addr_q & ~wrap_mask_q) | ((addr_q + nb) & wrap_mask_q) :
                                             (addr_q & ~(nb - ONE)) + nb;
        state_d     = state_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        wrap_mask_d = wrap_mask_q;
        size_d      = size_q;
        len_d       = len_q;
        idx_d       = idx_q;
        id_d        = id_q;
        err_d       = cmd_hs && illegal;
        if (cmd_hs && !illegal) begin
            state_d     = BURST;
            burst_d     = axi_burst_type'(cmd_burst_i);
            addr_d      = cmd_addr_i;
            wrap_mask_d = ((ADDR_WIDTH'(cmd_len_i) + ONE) << cmd_size_i) - ONE;
            size_d      = cmd_size_i;
            len_d       = cmd_len_i;
            idx_d       = 8'd0;
            id_d        = cmd_id_i;
        end
        if (beat_valid_o && beat_ready_i) begin
            state_d = beat_last_o ? IDLE : BURST;
            idx_d   = beat_last_o ? idx_q : idx_q + 8'd1;
            addr_d  = beat_last_o ? addr_q : next_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            burst_q     <= BURST_FIXED;
            addr_q      <= '0;
            wrap_mask_q <= '0;
            size_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            wrap_mask_q <= wrap_mask_d;
            size_q      <= size_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            id_q        <= id_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// tb_axi_burst_addr_gen: self-checking bench for axi_burst_addr_gen against an arithmetic burst model.
module tb_axi_burst_addr_gen;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic [3:0]  cmd_id = '0;
    logic        beat_valid;
    logic        beat_ready = 1'b0;
    logic [31:0] beat_addr;
    logic [7:0]  beat_strb;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic [3:0]  beat_id;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_size_i(cmd_size),
        .cmd_burst_i(cmd_burst), .cmd_id_i(cmd_id),
        .beat_valid_o(beat_valid), .beat_ready_i(beat_ready),
        .beat_addr_o(beat_addr), .beat_strb_o(beat_strb), .beat_idx_o(beat_idx),
        .beat_last_o(beat_last), .beat_id_o(beat_id), .err_o(err)
    );

    function automatic logic exp_illegal(input logic [31:0] a, input int len, input int size, input int burst);
        int unsigned nb;
        nb = 32'd1 << size;
        if (size > 3 || burst == 3) return 1'b1;
        if (burst == 2) return !(len == 1 || len == 3 || len == 7 || len == 15) || (a % nb != 0);
        if (burst == 1) return (a % 4096) - (a % nb) + (len + 1) * nb > 4096;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input int len, input int size,
                                             input int burst, input int n);
        logic [31:0] nb, total, lower;
        nb    = 32'd1 << size;
        total = nb * (len + 1);
        lower = a - (a % total);
        if (n == 0 || burst == 0) return a;
        if (burst == 1) return a - (a % nb) + n * nb;
        return lower + ((a - lower + n * nb) % total);
    endfunction

    function automatic logic [BW-1:0] exp_strb(input logic [31:0] a, input int size);
        int nb, lo, hi;
        logic [BW-1:0] s;
        s  = '0;
        nb = 1 << size;
        lo = int'(a % BW);
        hi = lo - (lo % nb) + nb - 1;
        for (int i = lo; i <= hi; i++) s[i] = 1'b1;
        return s;
    endfunction

    // mode 0: always ready, 1: random ready, 2: five stall cycles on beat 1
    task automatic run_cmd(input logic [31:0] a, input int len, input int size, input int burst,
                           input int mode, input string name);
        logic [3:0]    id;
        logic          ill;
        logic [31:0]   ea;
        logic [BW-1:0] es;
        int k, cyc, stall;
        id  = 4'($urandom);
        ill = exp_illegal(a, len, size, burst);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = 8'(len);
        cmd_size = 3'(size); cmd_burst = 2'(burst); cmd_id = id;
        @(posedge clk); #1;
        if (ill) begin
            cmd_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || beat_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s err_pulse: err=%b valid=%b ready=%b, expected 1 0 1", name, err, beat_valid, cmd_ready);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || beat_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s err_clear: err=%b valid=%b ready=%b, expected 0 0 1", name, err, beat_valid, cmd_ready);
            end
            return;
        end
        cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_size = 3'($urandom_range(0, 3));
        cmd_burst = 2'($urandom_range(0, 2)); cmd_id = 4'($urandom);
        k = 0; cyc = 0; stall = 0;
        while (k <= len && cyc < 300) begin
            beat_ready = mode == 1 ? 1'($urandom_range(0, 1)) : (mode == 2 && k == 1 && stall < 5) ? 1'b0 : 1'b1;
            if (mode == 2 && !beat_ready) stall++;
            ea = exp_addr(a, len, size, burst, k);
            es = exp_strb(ea, size);
            @(negedge clk);
            checks++;
            if (beat_valid !== 1'b1 || beat_addr !== ea || beat_strb !== es || beat_idx !== 8'(k) ||
                beat_last !== (k == len) || beat_id !== id || cmd_ready !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s beat%0d: valid=%b addr=%h strb=%h idx=%0d last=%b id=%h rdy=%b err=%b, expected 1 %h %h %0d %b %h 0 0",
                         name, k, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_id, cmd_ready, err,
                         ea, es, k, k == len, id);
            end
            @(posedge clk); #1;
            if (beat_ready) k++;
            cyc++;
        end
        cmd_valid = 1'b0;
        beat_ready = 1'b0;
        if (k <= len) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: accepted %0d beats, expected %0d", name, k, len + 1);
        end
        @(negedge clk);
        checks++;
        if (beat_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s bubble: valid=%b ready=%b, expected 0 1", name, beat_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_id, err} !== '0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b valid=%b addr=%h strb=%h idx=%0d last=%b id=%h err=%b, expected all 0",
                     cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_id, err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || beat_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b err=%b, expected 1 0 0", cmd_ready, beat_valid, err);
        end
    endtask

    task automatic test_incr();
        run_cmd(32'h1004, 3, 3, 1, 0, "incr");
    endtask

    task automatic test_wrap();
        run_cmd(32'h38, 3, 3, 2, 0, "wrap");
        run_cmd(32'h3C, 3, 3, 2, 0, "wrap_unaligned");
    endtask

    task automatic test_fixed();
        run_cmd(32'h102, 2, 1, 0, 0, "fixed");
    endtask

    task automatic test_backpressure();
        run_cmd(32'h1004, 3, 3, 1, 2, "backpressure");
    endtask

    task automatic test_errors();
        run_cmd(32'h1000, 0, 4, 1, 0, "err_size");
        run_cmd(32'hFF8, 1, 3, 1, 0, "err_4kb");
        run_cmd(32'h2000, 1, 3, 3, 0, "err_rsvd");
        run_cmd(32'hFF8, 0, 3, 1, 0, "incr_page_end");
    endtask

    task automatic test_reset_mid_burst();
        cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_len = 8'd7; cmd_size = 3'd3; cmd_burst = 2'd1; cmd_id = 4'h5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        beat_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (beat_valid !== 1'b1 || beat_idx !== 8'd2 || beat_addr !== 32'h210) begin
            errors++;
            $display("FAIL rst_mid_pre: valid=%b idx=%0d addr=%h, expected 1 2 00000210", beat_valid, beat_idx, beat_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_id, err} !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: ready=%b valid=%b addr=%h strb=%h idx=%0d last=%b id=%h err=%b, expected all 0",
                     cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_id, err);
        end
        rst = 1'b0;
        beat_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || beat_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: ready=%b valid=%b err=%b, expected 1 0 0", cmd_ready, beat_valid, err);
        end
        run_cmd(32'h3000, 2, 2, 1, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_cmd(32'h40, 7, 2, 2, 0, "b2b_a");
        run_cmd(32'h81, 4, 0, 1, 0, "b2b_b");
        run_cmd(32'h7, 3, 0, 0, 1, "b2b_c");
    endtask

    task automatic test_random();
        int burst, size, len, mode;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            burst = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
            size  = $urandom_range(0, 9) == 0 ? 4 : $urandom_range(0, 3);
            len   = burst == 2 ? ($urandom_range(0, 7) == 0 ? 2 : (2 << $urandom_range(0, 3)) - 1) : $urandom_range(0, 15);
            a     = $urandom;
            if (burst == 2 && $urandom_range(0, 7) != 0) a = a & ~((32'd1 << size) - 1);
            if (burst == 1 && $urandom_range(0, 3) == 0) a = {a[31:12], 12'hF00 | a[7:0]};
            mode  = $urandom_range(0, 2);
            run_cmd(a, len, size, burst, mode, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_backpressure();
        test_errors();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
